// File: rtl/msc_pkg.sv
// Shared types for the multi-channel select counter bank.
package msc_pkg;

  // Per-cycle command, decoded once at the top and broadcast to every channel.
  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_CLR  = 2'd1,
    CMD_LOAD = 2'd2,
    CMD_STEP = 2'd3
  } msc_cmd_e;

  // Clear beats load, and load beats step.
  function automatic msc_cmd_e msc_decode(input logic clr, input logic load, input logic en);
    if (clr)       return CMD_CLR;
    else if (load) return CMD_LOAD;
    else if (en)   return CMD_STEP;
    else           return CMD_NONE;
  endfunction

endpackage

// File: rtl/msc_channel.sv
// One counter channel: load / +-1 step with wrap or saturate, registered overflow pulse.
module msc_channel
  import msc_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Sel,
  input  msc_cmd_e         Cmd,
  input  logic             Dir,
  input  logic             Sat,
  input  logic [WIDTH-1:0] LoadVal,
  output logic [WIDTH-1:0] Count,
  output logic             Ovf
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   nxt;

  // Next state: the extra top bit of nxt is the carry (up) or borrow (down).
  always_comb begin
    nxt   = Dir ? ({1'b0, cnt_q} - {{WIDTH{1'b0}}, 1'b1})
                : ({1'b0, cnt_q} + {{WIDTH{1'b0}}, 1'b1});
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unique case (Cmd)
      CMD_CLR:  cnt_d = '0;
      CMD_LOAD: if (Sel) cnt_d = LoadVal;
      CMD_STEP: if (Sel) begin
        ovf_d = nxt[WIDTH];
        // Saturation simply refuses the wrapping step; the pulse still fires.
        cnt_d = (nxt[WIDTH] && Sat) ? cnt_q : nxt[WIDTH-1:0];
      end
      default: ;
    endcase
  end

  // Counter and overflow-pulse registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign Count = cnt_q;
  assign Ovf   = ovf_q;

endmodule

// File: rtl/multi_select_counter.sv
// N-channel select counter bank: one command port steered to a channel by Slt.
module multi_select_counter
  import msc_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int CHANNELS = 4
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Clr,
  input  logic                          En,
  input  logic                          Dir,
  input  logic                          Sat,
  input  logic                          Load,
  input  logic [WIDTH-1:0]              LoadVal,
  input  logic [$clog2(CHANNELS)-1:0]   Slt,
  output logic [CHANNELS*WIDTH-1:0]     Count,
  output logic [CHANNELS-1:0]           Ovf,
  output logic                          SelErr
);

  localparam int SEL_W = $clog2(CHANNELS);
  localparam int SEL_N = 2 ** SEL_W;

  msc_cmd_e         cmd;
  logic [SEL_N-1:0] sel_oh;
  logic             sel_ok;
  logic             selerr_q, selerr_d;

  // Command decode and one-hot select; codes past the last channel land in
  // the unused upper bits of sel_oh and so address nothing.
  always_comb begin
    cmd         = msc_decode(Clr, Load, En);
    sel_oh      = '0;
    sel_oh[Slt] = 1'b1;
    sel_ok      = |sel_oh[CHANNELS-1:0];
    selerr_d    = ((cmd == CMD_LOAD) || (cmd == CMD_STEP)) && !sel_ok;
  end

  // Select-error pulse register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) selerr_q <= 1'b0;
    else        selerr_q <= selerr_d;
  end

  assign SelErr = selerr_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    msc_channel #(.WIDTH(WIDTH)) u_ch (
      .Clk     (Clk),
      .Reset   (Reset),
      .Sel     (sel_oh[i]),
      .Cmd     (cmd),
      .Dir     (Dir),
      .Sat     (Sat),
      .LoadVal (LoadVal),
      .Count   (Count[i*WIDTH +: WIDTH]),
      .Ovf     (Ovf[i])
    );
  end

endmodule

// File: tb/tb_multi_select_counter.sv
// Bench for multi_select_counter: a 4x64 instance and a 3x8 instance.
module tb_multi_select_counter;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  // 4-channel, 64-bit instance
  logic         clr4 = 0, en4 = 0, dir4 = 0, sat4 = 0, load4 = 0;
  logic [63:0]  lv4 = '0;
  logic [1:0]   slt4 = '0;
  logic [255:0] c4;
  logic [3:0]   o4;
  logic         se4;

  // 3-channel, 8-bit instance (has an illegal select code)
  logic         clr3 = 0, en3 = 0, dir3 = 0, sat3 = 0, load3 = 0;
  logic [7:0]   lv3 = '0;
  logic [1:0]   slt3 = '0;
  logic [23:0]  c3;
  logic [2:0]   o3;
  logic         se3;

  multi_select_counter #(.WIDTH(64), .CHANNELS(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .Clr(clr4), .En(en4), .Dir(dir4), .Sat(sat4),
    .Load(load4), .LoadVal(lv4), .Slt(slt4), .Count(c4), .Ovf(o4), .SelErr(se4));

  multi_select_counter #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .Clk(Clk), .Reset(Reset), .Clr(clr3), .En(en3), .Dir(dir3), .Sat(sat3),
    .Load(load3), .LoadVal(lv3), .Slt(slt3), .Count(c3), .Ovf(o3), .SelErr(se3));

  typedef struct {
    string       nm;
    logic        clr, load, en, dir, sat;
    logic [1:0]  slt;
    logic [63:0] lv;
    int          ch;
    logic [63:0] val;
    logic [3:0]  ovf;
    logic        selerr;
  } vec_t;

  typedef struct {
    string       nm;
    int          dut;
    int          ch;
    logic [63:0] val;
    logic [3:0]  ovf;
    logic        selerr;
  } sb_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  function automatic vec_t mk(string nm, logic clr, logic load, logic en, logic dir, logic sat,
                              logic [1:0] slt, logic [63:0] lv, int ch, logic [63:0] val,
                              logic [3:0] ovf, logic selerr);
    vec_t v;
    v.nm = nm; v.clr = clr; v.load = load; v.en = en; v.dir = dir; v.sat = sat;
    v.slt = slt; v.lv = lv; v.ch = ch; v.val = val; v.ovf = ovf; v.selerr = selerr;
    return v;
  endfunction

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one command, queue its expected result, then compare one edge later.
  task automatic step(int dut, vec_t v);
    sb_t e;
    if (dut == 4) begin
      clr4 = v.clr; load4 = v.load; en4 = v.en; dir4 = v.dir; sat4 = v.sat;
      slt4 = v.slt; lv4 = v.lv;
    end else begin
      clr3 = v.clr; load3 = v.load; en3 = v.en; dir3 = v.dir; sat3 = v.sat;
      slt3 = v.slt; lv3 = v.lv[7:0];
    end
    e.nm = v.nm; e.dut = dut; e.ch = v.ch; e.val = v.val; e.ovf = v.ovf; e.selerr = v.selerr;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    if (e.dut == 4) begin
      chk({e.nm, ".cnt"}, {192'd0, c4[e.ch*64 +: 64]}, {192'd0, e.val});
      chk({e.nm, ".ovf"}, {252'd0, o4}, {252'd0, e.ovf});
      chk({e.nm, ".selerr"}, {255'd0, se4}, {255'd0, e.selerr});
    end else begin
      chk({e.nm, ".cnt"}, {248'd0, c3[e.ch*8 +: 8]}, {192'd0, e.val});
      chk({e.nm, ".ovf"}, {253'd0, o3}, {252'd0, e.ovf});
      chk({e.nm, ".selerr"}, {255'd0, se3}, {255'd0, e.selerr});
    end
  endtask

  vec_t tbl[$];
  vec_t t3[$];

  initial begin
    //            name        clr ld en dir sat slt lv          ch val          ovf      se
    for (int i = 1; i <= 5; i++)
      tbl.push_back(mk($sformatf("up%0d", i), 0,0,1,0,0, 2, 0, 2, 64'(i), 4'b0000, 0));
    tbl.push_back(mk("ld1_ones",  0,1,0,0,0, 1, ONES,    1, ONES,     4'b0000, 0));
    tbl.push_back(mk("wrap_up",   0,0,1,0,0, 1, 0,       1, 0,        4'b0010, 0));
    tbl.push_back(mk("ovf_drop",  0,0,1,0,0, 2, 0,       2, 6,        4'b0000, 0));
    tbl.push_back(mk("ld1_ones2", 0,1,0,0,1, 1, ONES,    1, ONES,     4'b0000, 0));
    tbl.push_back(mk("sat_up1",   0,0,1,0,1, 1, 0,       1, ONES,     4'b0010, 0));
    tbl.push_back(mk("sat_up2",   0,0,1,0,1, 1, 0,       1, ONES,     4'b0010, 0));
    tbl.push_back(mk("sat_idle",  0,0,0,0,1, 1, 0,       1, ONES,     4'b0000, 0));
    tbl.push_back(mk("ld3_zero",  0,1,0,0,0, 3, 0,       3, 0,        4'b0000, 0));
    tbl.push_back(mk("wrap_dn",   0,0,1,1,0, 3, 0,       3, ONES,     4'b1000, 0));
    tbl.push_back(mk("ld3_zero2", 0,1,0,0,0, 3, 0,       3, 0,        4'b0000, 0));
    tbl.push_back(mk("sat_dn",    0,0,1,1,1, 3, 0,       3, 0,        4'b1000, 0));
    tbl.push_back(mk("sat_dn_up", 0,0,1,0,1, 3, 0,       3, 1,        4'b0000, 0));
    tbl.push_back(mk("dn_plain",  0,0,1,1,0, 3, 0,       3, 0,        4'b0000, 0));
    tbl.push_back(mk("ld_over_en",0,1,1,0,0, 0, 64'h1234,0, 64'h1234, 4'b0000, 0));
    tbl.push_back(mk("dn_1234",   0,0,1,1,0, 0, 0,       0, 64'h1233, 4'b0000, 0));
    tbl.push_back(mk("clr_ld",    1,1,1,0,0, 0, 64'h55,  0, 0,        4'b0000, 0));

    t3.push_back(mk("c3_up1",     0,0,1,0,0, 0, 0,       0, 1,        4'b0000, 0));
    t3.push_back(mk("c3_up2",     0,0,1,0,0, 0, 0,       0, 2,        4'b0000, 0));
    t3.push_back(mk("c3_bad_en",  0,0,1,0,0, 3, 0,       0, 2,        4'b0000, 1));
    t3.push_back(mk("c3_idle",    0,0,0,0,0, 3, 0,       0, 2,        4'b0000, 0));
    t3.push_back(mk("c3_bad_ld",  0,1,0,0,0, 3, 8'hAA,   0, 2,        4'b0000, 1));
    t3.push_back(mk("c3_ld2",     0,1,0,0,0, 2, 8'hFF,   2, 8'hFF,    4'b0000, 0));
    t3.push_back(mk("c3_wrap",    0,0,1,0,0, 2, 0,       2, 0,        4'b0100, 0));
    t3.push_back(mk("c3_satdn",   0,0,1,1,1, 1, 0,       1, 0,        4'b0010, 0));

    // Reset state, asynchronous
    #1;
    chk("rst.c4",  c4, '0);
    chk("rst.o4",  {252'd0, o4}, '0);
    chk("rst.c3",  {232'd0, c3}, '0);
    chk("rst.se",  {254'd0, se4, se3}, '0);
    #3 Reset = 1'b1;                 // release between edges
    @(posedge Clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(4, tbl[i]);
      if (i == 4) chk("bus_after_5up", c4, {64'd0, 64'd5, 64'd0, 64'd0});
    end
    chk("bus_after_clr", c4, '0);

    // Mid-cycle async reset while counting
    step(4, mk("ld0_7", 0,1,0,0,0, 0, 7, 0, 7, 4'b0000, 0));
    load4 = 0; en4 = 1; slt4 = 0; dir4 = 0; sat4 = 0;
    #3 Reset = 1'b0;
    #1;
    chk("midrst.c4", c4, '0);
    chk("midrst.o4", {252'd0, o4}, '0);
    #2 Reset = 1'b1;
    @(posedge Clk); #1;
    chk("post_rst.ch0", {192'd0, c4[63:0]}, 256'd1);
    step(4, mk("post_rst2", 0,0,1,0,0, 0, 0, 0, 2, 4'b0000, 0));
    step(4, mk("idle4", 0,0,0,0,0, 0, 0, 0, 2, 4'b0000, 0));

    for (int i = 0; i < t3.size(); i++) begin
      step(3, t3[i]);
      if (i == 2) chk("c3_bus_selerr", {232'd0, c3}, 256'h000002);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
